dma_slave_axi_if: RTL and testbench
===================================

// Module: dma_slave_axi_if
// PURPOSE
// AXI4 slave front end for the DMA configuration register file. Accepts AW/W/B and AR/R bursts from the bus.
// Converts them into the register file's single-cycle write port (web/w_index/w_data).
// Converts them into its combinational read port (r_index -> r_data). Sits directly upstream of the DMA register file.
// The write and read paths are independent FSMs and may be active in the same cycle.
// PARAMETERS
// ID_W       8   AXI transaction ID width (AWID/ARID/BID/RID)
// ADDR_W     32  AXI address width
// DATA_W     32  AXI data width; equal to register width
// IDX_W      3   register index width; index = ADDR[IDX_W+1:2]
// REG_LEN    8   number of implemented registers; index >= REG_LEN is out of range
// PORTS
// ACLK         in   1       clock, all state on rising edge
// ARESET       in   1       asynchronous, active-high reset
// AWID/AWADDR  in   ID_W/ADDR_W   write address channel
// AWLEN/AWBURST in  8/2     beats-1; 2'b00 FIXED, other values treated as INCR
// AWVALID/AWREADY in/out 1  AW handshake
// WDATA/WSTRB  in   DATA_W/DATA_W/8  write data, byte strobes
// WLAST/WVALID in   1/1     last beat, valid;  WREADY out 1
// BID/BRESP    out  ID_W/2  response ID, 2'b00 OKAY / 2'b10 SLVERR
// BVALID out 1; BREADY in 1 B handshake
// ARID/ARADDR/ARLEN/ARBURST in ID_W/ADDR_W/8/2  read address channel, same burst rules as AW
// ARVALID/ARREADY in/out 1  AR handshake
// RID/RDATA/RRESP/RLAST out ID_W/DATA_W/2/1  read data channel
// RVALID out 1; RREADY in 1 R handshake
// reg_web      out  1       register write enable (one cycle per accepted, legal beat)
// reg_w_index  out  IDX_W   register write index
// reg_w_data   out  DATA_W  register write data (= WDATA)
// reg_r_index  out  IDX_W   register read index (combinational)
// reg_r_data   in   DATA_W  register read data, combinational from reg_r_index
// BEHAVIOUR
// Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE. AWREADY=(W_IDLE), WREADY=(W_DATA), BVALID=(W_RESP).
// - AW handshake: latch AWID, index=AWADDR[IDX_W+1:2], len=AWLEN, beat_cnt=0, err=0. Go to W_DATA.
// - W beat (WVALID&WREADY): reg_web=1 combinationally in the same cycle iff index<REG_LEN and WSTRB all ones.
//   Otherwise the beat is dropped and err is set. If WLAST != (beat_cnt==len), err is set.
// - After each beat: INCR index+1 (wraps modulo 2^IDX_W); FIXED index held. beat_cnt+1.
// - Beat with beat_cnt==len -> W_RESP. BRESP = err ? SLVERR : OKAY. BID=latched AWID.
// - BVALID held until BREADY; handshake -> W_IDLE. No new AW is accepted before B completes.
// Read FSM R_IDLE -> R_DATA -> R_IDLE. ARREADY=(R_IDLE), RVALID=(R_DATA).
// - reg_r_index = ARADDR index in R_IDLE, else next-beat index (index+1 INCR, index FIXED).
// - AR handshake at edge k: RDATA register loads reg_r_data (0 if out of range). RVALID=1 from cycle k+1.
// - R handshake not last: RDATA reloads next beat, index/beat_cnt advance. No bubble between beats.
// - RLAST=(beat_cnt==len). RRESP per beat: SLVERR iff that beat's index>=REG_LEN. RID=latched ARID.
// - RDATA/RRESP/RLAST/RID stable while RVALID&!RREADY, even if a write hits the same register.
// - RLAST beat handshake -> R_IDLE.
// Same-cycle write and read to one register: the read captures the pre-write value. The write lands at that edge.
// Reset (ARESET high, any cycle, mid-burst included):
// - both FSMs go to IDLE and all latched state clears.
// - BVALID=RVALID=WREADY=reg_web=0, AWREADY=ARREADY=1.
// - BID=RID=0, BRESP=RRESP=0, RDATA=0, RLAST=0.
// - A partially written burst keeps the beats already written; no B response is issued.
// TESTING
// Single write AW idx2 LEN0 data 0xDEADBEEF WSTRB 0xF -> one reg_web pulse idx2. BRESP OKAY, BID echoes AWID.
// INCR write LEN3 from idx6 -> reg_web at idx 6,7,0,1. Then INCR read LEN3 from idx6 -> same 4 words, RLAST on beat 4 only.
// Write with WSTRB 0x3 or idx>=REG_LEN (REG_LEN=6, idx6) -> no reg_web, BRESP SLVERR. Read of idx6 -> RDATA 0, RRESP SLVERR.
// Backpressure: RREADY low 5 cycles -> RDATA stable despite a concurrent write to the same register. BREADY low 3 cycles -> BVALID held.
// ARESET asserted mid 4-beat write after beat 2 -> 2 registers updated, FSMs idle, no BVALID. A fresh burst then completes OKAY.

Source files
------------

// File: rtl/dma_slave_axi_if.sv
// AXI4 slave front end for the DMA configuration register file.
// Independent write (AW/W/B) and read (AR/R) FSMs drive the register file's write and read ports.
module dma_slave_axi_if #(
  parameter int ID_W    = 8,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int IDX_W   = 3,
  parameter int REG_LEN = 8
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [ID_W-1:0]   AWID,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic [7:0]        AWLEN,
  input  logic [1:0]        AWBURST,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [DATA_W-1:0] WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic              WLAST,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [ID_W-1:0]   BID,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  input  logic [ID_W-1:0]   ARID,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [7:0]        ARLEN,
  input  logic [1:0]        ARBURST,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [ID_W-1:0]   RID,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY,
  output logic              reg_web,
  output logic [IDX_W-1:0]  reg_w_index,
  output logic [DATA_W-1:0] reg_w_data,
  output logic [IDX_W-1:0]  reg_r_index,
  input  logic [DATA_W-1:0] reg_r_data
);

  // state   | meaning
  // W_IDLE  | waiting for AW
  // W_DATA  | accepting W beats
  // W_RESP  | presenting B response
  // R_IDLE  | waiting for AR
  // R_DATA  | presenting R beats

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return (32'(idx) < REG_LEN);
  endfunction

  w_state_t          w_state, w_state_nxt;
  logic [ID_W-1:0]   w_id;
  logic [IDX_W-1:0]  w_idx;
  logic [7:0]        w_len, w_cnt;
  logic              w_err, w_fixed;
  logic              aw_hs, w_hs, w_last_beat, w_beat_ok;

  r_state_t          r_state, r_state_nxt;
  logic [ID_W-1:0]   r_id;
  logic [IDX_W-1:0]  r_idx, r_idx_nxt;
  logic [7:0]        r_len, r_cnt;
  logic              r_fixed;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;
  logic              rlast_q;
  logic              ar_hs, r_hs, r_load;

  // Address bits outside the register window are ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{AWADDR[ADDR_W-1:IDX_W+2], AWADDR[1:0],
                              ARADDR[ADDR_W-1:IDX_W+2], ARADDR[1:0]};

  // ---------------- write path ----------------
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) w_state <= W_IDLE;
    else        w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_state;
    AWREADY     = 1'b0;
    WREADY      = 1'b0;
    BVALID      = 1'b0;
    case (w_state)
      W_IDLE: begin
        AWREADY = 1'b1;
        if (AWVALID) w_state_nxt = W_DATA;
      end
      W_DATA: begin
        WREADY = 1'b1;
        if (WVALID && w_last_beat) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        BVALID = 1'b1;
        if (BREADY) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  assign aw_hs       = AWVALID & AWREADY;
  assign w_hs        = WVALID & WREADY;
  assign w_last_beat = (w_cnt == w_len);
  assign w_beat_ok   = in_range(w_idx) & (&WSTRB);

  assign reg_web     = w_hs & w_beat_ok;
  assign reg_w_index = w_idx;
  assign reg_w_data  = WDATA;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_id    <= '0;
      w_idx   <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
      w_fixed <= 1'b0;
    end else if (aw_hs) begin
      w_id    <= AWID;
      w_idx   <= AWADDR[IDX_W+1:2];
      w_len   <= AWLEN;
      w_cnt   <= '0;
      w_err   <= 1'b0;
      w_fixed <= (AWBURST == BURST_FIXED);
    end else if (w_hs) begin
      // Illegal beats are dropped but still consume a slot in the burst.
      w_err <= w_err | ~w_beat_ok | (WLAST != w_last_beat);
      w_cnt <= w_cnt + 8'd1;
      if (!w_fixed) w_idx <= w_idx + 1'b1;
    end
  end

  assign BID   = w_id;
  assign BRESP = w_err ? RESP_SLVERR : RESP_OKAY;

  // ---------------- read path ----------------
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_state <= R_IDLE;
    else        r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    ARREADY     = 1'b0;
    RVALID      = 1'b0;
    case (r_state)
      R_IDLE: begin
        ARREADY = 1'b1;
        if (ARVALID) r_state_nxt = R_DATA;
      end
      R_DATA: begin
        RVALID = 1'b1;
        if (RREADY && rlast_q) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  assign ar_hs       = ARVALID & ARREADY;
  assign r_hs        = RVALID & RREADY;
  assign r_load      = ar_hs | (r_hs & ~rlast_q);
  assign r_idx_nxt   = r_fixed ? r_idx : r_idx + 1'b1;
  // Look-ahead index so the next beat is ready the cycle the current one is taken.
  assign reg_r_index = (r_state == R_IDLE) ? ARADDR[IDX_W+1:2] : r_idx_nxt;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_id    <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_fixed <= 1'b0;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
      rlast_q <= 1'b0;
    end else begin
      if (ar_hs) begin
        r_id    <= ARID;
        r_idx   <= ARADDR[IDX_W+1:2];
        r_len   <= ARLEN;
        r_cnt   <= '0;
        r_fixed <= (ARBURST == BURST_FIXED);
        rlast_q <= (ARLEN == 8'd0);
      end else if (r_hs && !rlast_q) begin
        r_idx   <= r_idx_nxt;
        r_cnt   <= r_cnt + 8'd1;
        rlast_q <= ((r_cnt + 8'd1) == r_len);
      end
      if (r_load) begin
        rdata_q <= in_range(reg_r_index) ? reg_r_data : '0;
        rresp_q <= in_range(reg_r_index) ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign RID   = r_id;
  assign RDATA = rdata_q;
  assign RRESP = rresp_q;
  assign RLAST = rlast_q;

endmodule

// File: tb/tb_dma_slave_axi_if.sv
// Directed bench for dma_slave_axi_if: two instances (REG_LEN 8 and 6) share one bus stimulus,
// each backed by a behavioural register file.
module tb_dma_slave_axi_if;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  logic [7:0]  awid, arid;
  logic [31:0] awaddr, araddr, wdata;
  logic [7:0]  awlen, arlen;
  logic [1:0]  awburst, arburst;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, wlast, bready, arvalid, rready;

  logic        awready_a, wready_a, bvalid_a, arready_a, rvalid_a, rlast_a, web_a;
  logic [7:0]  bid_a, rid_a;
  logic [1:0]  bresp_a, rresp_a;
  logic [31:0] rdata_a, wdo_a, rdin_a;
  logic [2:0]  widx_a, ridx_a;

  logic        awready_b, wready_b, bvalid_b, arready_b, rvalid_b, rlast_b, web_b;
  logic [7:0]  bid_b, rid_b;
  logic [1:0]  bresp_b, rresp_b;
  logic [31:0] rdata_b, wdo_b, rdin_b;
  logic [2:0]  widx_b, ridx_b;

  dma_slave_axi_if #(.REG_LEN(8)) u_dut_a (
    .ACLK(aclk), .ARESET(areset),
    .AWID(awid), .AWADDR(awaddr), .AWLEN(awlen), .AWBURST(awburst), .AWVALID(awvalid), .AWREADY(awready_a),
    .WDATA(wdata), .WSTRB(wstrb), .WLAST(wlast), .WVALID(wvalid), .WREADY(wready_a),
    .BID(bid_a), .BRESP(bresp_a), .BVALID(bvalid_a), .BREADY(bready),
    .ARID(arid), .ARADDR(araddr), .ARLEN(arlen), .ARBURST(arburst), .ARVALID(arvalid), .ARREADY(arready_a),
    .RID(rid_a), .RDATA(rdata_a), .RRESP(rresp_a), .RLAST(rlast_a), .RVALID(rvalid_a), .RREADY(rready),
    .reg_web(web_a), .reg_w_index(widx_a), .reg_w_data(wdo_a), .reg_r_index(ridx_a), .reg_r_data(rdin_a)
  );

  dma_slave_axi_if #(.REG_LEN(6)) u_dut_b (
    .ACLK(aclk), .ARESET(areset),
    .AWID(awid), .AWADDR(awaddr), .AWLEN(awlen), .AWBURST(awburst), .AWVALID(awvalid), .AWREADY(awready_b),
    .WDATA(wdata), .WSTRB(wstrb), .WLAST(wlast), .WVALID(wvalid), .WREADY(wready_b),
    .BID(bid_b), .BRESP(bresp_b), .BVALID(bvalid_b), .BREADY(bready),
    .ARID(arid), .ARADDR(araddr), .ARLEN(arlen), .ARBURST(arburst), .ARVALID(arvalid), .ARREADY(arready_b),
    .RID(rid_b), .RDATA(rdata_b), .RRESP(rresp_b), .RLAST(rlast_b), .RVALID(rvalid_b), .RREADY(rready),
    .reg_web(web_b), .reg_w_index(widx_b), .reg_w_data(wdo_b), .reg_r_index(ridx_b), .reg_r_data(rdin_b)
  );

  // Behavioural register files plus a log of write indices (one nibble per pulse).
  logic [31:0] regs_a [8] = '{default: 32'h0};
  logic [31:0] regs_b [8] = '{default: 32'h0};
  int          web_cnt_a = 0, web_cnt_b = 0;
  logic [31:0] web_hist_a = '0, web_hist_b = '0;

  always @(posedge aclk) begin
    if (web_a) begin
      regs_a[widx_a] <= wdo_a;
      web_cnt_a      <= web_cnt_a + 1;
      web_hist_a     <= {web_hist_a[27:0], 1'b0, widx_a};
    end
    if (web_b) begin
      regs_b[widx_b] <= wdo_b;
      web_cnt_b      <= web_cnt_b + 1;
      web_hist_b     <= {web_hist_b[27:0], 1'b0, widx_b};
    end
  end
  assign rdin_a = regs_a[ridx_a];
  assign rdin_b = regs_b[ridx_b];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic aw_send(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
    int n = 0;
    awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    while (!(awready_a && awready_b) && n < 50) begin @(negedge aclk); n++; end
    check("aw_timeout", 64'(n < 50), 64'd1);
    @(negedge aclk);
    awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n = 0;
    wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
    while (!(wready_a && wready_b) && n < 50) begin @(negedge aclk); n++; end
    check("w_timeout", 64'(n < 50), 64'd1);
    @(negedge aclk);
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic b_recv(input string tag, input logic [7:0] id, input logic [1:0] exp_a,
                        input logic [1:0] exp_b, input int stall);
    int n = 0;
    bready = 1'b0;
    while (!bvalid_a && n < 50) begin @(negedge aclk); n++; end
    check({tag, " b_timeout"}, 64'(n < 50), 64'd1);
    for (int i = 0; i < stall; i++) begin
      check({tag, " bvalid_held"}, 64'(bvalid_a), 64'd1);
      @(negedge aclk);
    end
    check({tag, " bvalid_b"}, 64'(bvalid_b), 64'd1);
    check({tag, " bid"}, 64'(bid_a), 64'(id));
    check({tag, " bresp_a"}, 64'(bresp_a), 64'(exp_a));
    check({tag, " bresp_b"}, 64'(bresp_b), 64'(exp_b));
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    check({tag, " bvalid_clear"}, 64'(bvalid_a), 64'd0);
  endtask

  task automatic wr_burst(input string tag, input logic [7:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic [1:0] burst, input logic [3:0][31:0] d,
                          input logic [3:0] strb, input logic [3:0] lastm, input int stall,
                          input logic [1:0] exp_a, input logic [1:0] exp_b);
    aw_send(id, addr, len, burst);
    for (int i = 0; i <= int'(len); i++) w_send(d[i], strb, lastm[i]);
    b_recv(tag, id, exp_a, exp_b, stall);
  endtask

  task automatic rd_burst(input string tag, input logic [7:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic [1:0] burst,
                          input logic [3:0][31:0] ea, input logic [3:0][31:0] eb,
                          input logic [3:0][1:0] ra, input logic [3:0][1:0] rb, input int stall);
    int n = 0;
    arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
    while (!arready_a && n < 50) begin @(negedge aclk); n++; end
    @(negedge aclk);
    arvalid = 1'b0;
    while (!rvalid_a && n < 50) begin @(negedge aclk); n++; end
    check({tag, " r_timeout"}, 64'(n < 50), 64'd1);
    rready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      check($sformatf("%s rdata_stall%0d", tag, s), 64'(rdata_a), 64'(ea[0]));
      @(negedge aclk);
    end
    rready = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      check($sformatf("%s rvalid[%0d]", tag, i), 64'(rvalid_a), 64'd1);
      check($sformatf("%s rdata_a[%0d]", tag, i), 64'(rdata_a), 64'(ea[i]));
      check($sformatf("%s rresp_a[%0d]", tag, i), 64'(rresp_a), 64'(ra[i]));
      check($sformatf("%s rlast[%0d]", tag, i), 64'(rlast_a), 64'(i == int'(len)));
      check($sformatf("%s rid[%0d]", tag, i), 64'(rid_a), 64'(id));
      check($sformatf("%s rdata_b[%0d]", tag, i), 64'(rdata_b), 64'(eb[i]));
      check($sformatf("%s rresp_b[%0d]", tag, i), 64'(rresp_b), 64'(rb[i]));
      @(negedge aclk);
    end
    rready = 1'b0;
    check({tag, " rvalid_clear"}, 64'(rvalid_a), 64'd0);
  endtask

  localparam logic [1:0] OK = 2'b00, SE = 2'b10, FIX = 2'b00, INC = 2'b01;
  int ca, cb;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    awid = '0; awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;

    repeat (2) @(negedge aclk);
    check("rst awready", 64'(awready_a), 64'd1);
    check("rst arready", 64'(arready_a), 64'd1);
    check("rst wready", 64'(wready_a), 64'd0);
    check("rst bvalid", 64'(bvalid_a), 64'd0);
    check("rst rvalid", 64'(rvalid_a), 64'd0);
    check("rst rdata", 64'(rdata_a), 64'd0);
    areset = 1'b0;
    @(negedge aclk);

    // single write, B backpressure 3 cycles
    ca = web_cnt_a;
    wr_burst("single", 8'h5A, 32'h8, 8'd0, INC, {96'h0, 32'hDEADBEEF}, 4'hF, 4'b0001, 3, OK, OK);
    check("single web_cnt", 64'(web_cnt_a - ca), 64'd1);
    check("single web_idx", 64'(web_hist_a[3:0]), 64'h2);
    check("single reg2", 64'(regs_a[2]), 64'hDEADBEEF);

    wr_burst("pre3", 8'h03, 32'hC, 8'd0, INC, {96'h0, 32'hCAFE0003}, 4'hF, 4'b0001, 0, OK, OK);

    // INCR write from idx6 wraps to 0; instance b drops idx 6,7
    ca = web_cnt_a; cb = web_cnt_b;
    wr_burst("incr_w", 8'h21, 32'h18, 8'd3, INC,
             {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 4'hF, 4'b1000, 0, OK, SE);
    check("incr_w cnt_a", 64'(web_cnt_a - ca), 64'd4);
    check("incr_w idx_a", 64'(web_hist_a[15:0]), 64'h6701);
    check("incr_w cnt_b", 64'(web_cnt_b - cb), 64'd2);
    check("incr_w idx_b", 64'(web_hist_b[7:0]), 64'h01);

    rd_burst("incr_r", 8'h33, 32'h18, 8'd3, INC,
             {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
             {32'h44444444, 32'h33333333, 32'h0, 32'h0},
             {OK, OK, OK, OK}, {OK, OK, SE, SE}, 0);

    // partial strobe: no write, SLVERR
    ca = web_cnt_a; cb = web_cnt_b;
    wr_burst("strb", 8'h44, 32'h8, 8'd0, INC, {96'h0, 32'h0BADF00D}, 4'h3, 4'b0001, 0, SE, SE);
    check("strb cnt_a", 64'(web_cnt_a - ca), 64'd0);
    check("strb cnt_b", 64'(web_cnt_b - cb), 64'd0);
    check("strb reg2", 64'(regs_a[2]), 64'hDEADBEEF);

    // FIXED burst keeps the index
    ca = web_cnt_a;
    wr_burst("fixed", 8'h46, 32'h10, 8'd1, FIX, {64'h0, 32'hAAAA0002, 32'hAAAA0001}, 4'hF, 4'b0010, 0, OK, OK);
    check("fixed cnt", 64'(web_cnt_a - ca), 64'd2);
    check("fixed idx", 64'(web_hist_a[7:0]), 64'h44);
    check("fixed reg4", 64'(regs_a[4]), 64'hAAAA0002);
    rd_burst("fixed_r", 8'h47, 32'h10, 8'd1, FIX, {64'h0, 32'hAAAA0002, 32'hAAAA0002},
             {64'h0, 32'hAAAA0002, 32'hAAAA0002}, {OK, OK, OK, OK}, {OK, OK, OK, OK}, 0);

    // WLAST on the wrong beat: data still written, SLVERR
    ca = web_cnt_a; cb = web_cnt_b;
    wr_burst("wlast", 8'h48, 32'h14, 8'd1, INC, {64'h0, 32'h66660000, 32'h55550000}, 4'hF, 4'b0001, 0, SE, SE);
    check("wlast cnt_a", 64'(web_cnt_a - ca), 64'd2);
    check("wlast idx_a", 64'(web_hist_a[7:0]), 64'h56);
    check("wlast cnt_b", 64'(web_cnt_b - cb), 64'd1);
    check("wlast idx_b", 64'(web_hist_b[3:0]), 64'h5);

    // R stalled 5 cycles while a write hits the same register
    fork
      rd_burst("stall_r", 8'h61, 32'hC, 8'd0, INC, {96'h0, 32'hCAFE0003}, {96'h0, 32'hCAFE0003},
               {OK, OK, OK, OK}, {OK, OK, OK, OK}, 5);
      begin
        @(negedge aclk);
        wr_burst("stall_w", 8'h62, 32'hC, 8'd0, INC, {96'h0, 32'h12345678}, 4'hF, 4'b0001, 0, OK, OK);
      end
    join
    rd_burst("after_r", 8'h63, 32'hC, 8'd0, INC, {96'h0, 32'h12345678}, {96'h0, 32'h12345678},
             {OK, OK, OK, OK}, {OK, OK, OK, OK}, 0);

    // reset after beat 2 of a 4-beat write
    ca = web_cnt_a;
    aw_send(8'h77, 32'h0, 8'd3, INC);
    w_send(32'hE0E0E0E0, 4'hF, 1'b0);
    w_send(32'hE1E1E1E1, 4'hF, 1'b0);
    wdata = 32'hE2E2E2E2; wstrb = 4'hF; wvalid = 1'b1;
    areset = 1'b1;
    #1;
    check("mid_rst web", 64'(web_a), 64'd0);
    check("mid_rst wready", 64'(wready_a), 64'd0);
    check("mid_rst awready", 64'(awready_a), 64'd1);
    check("mid_rst arready", 64'(arready_a), 64'd1);
    check("mid_rst bvalid", 64'(bvalid_a), 64'd0);
    check("mid_rst rvalid", 64'(rvalid_a), 64'd0);
    check("mid_rst bid", 64'(bid_a), 64'd0);
    check("mid_rst rid", 64'(rid_a), 64'd0);
    check("mid_rst rdata", 64'(rdata_a), 64'd0);
    check("mid_rst bresp", 64'(bresp_a), 64'd0);
    check("mid_rst rlast", 64'(rlast_a), 64'd0);
    repeat (2) @(negedge aclk);
    wvalid = 1'b0;
    areset = 1'b0;
    repeat (3) begin
      @(negedge aclk);
      check("post_rst bvalid", 64'(bvalid_a), 64'd0);
    end
    check("rst cnt", 64'(web_cnt_a - ca), 64'd2);
    check("rst idx", 64'(web_hist_a[7:0]), 64'h01);
    check("rst reg0", 64'(regs_a[0]), 64'hE0E0E0E0);
    check("rst reg1", 64'(regs_a[1]), 64'hE1E1E1E1);
    check("rst reg2", 64'(regs_a[2]), 64'hDEADBEEF);
    wr_burst("fresh", 8'h78, 32'h14, 8'd0, INC, {96'h0, 32'hF00DF00D}, 4'hF, 4'b0001, 0, OK, OK);
    check("fresh reg5", 64'(regs_a[5]), 64'hF00DF00D);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
